// File: rtl/spi_rx_module.sv
// SPI receive path: shifts MISO in MSB first on each SCK rising-edge pulse and
// queues completed bytes in a small first-word-fall-through FIFO.
module spi_rx_module #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       MISO,
  input  logic       En,
  input  logic       L2H_Sig,
  input  logic       Rd_En,
  input  logic       Clr_Ovr,
  output logic       Busy_Sig,
  output logic       Done_Sig,
  output logic [7:0] Data,
  output logic       Empty_Sig,
  output logic       Full_Sig,
  output logic       Overrun_Sig,
  output logic [1:0] Sta_Dbg
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]    sta;
  logic [7:0]    shift_reg;
  logic [2:0]    bit_cnt;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_ptr_n;
  logic [CW-1:0] count;
  logic [CW-1:0] count_n;
  logic          push;
  logic          pop;
  logic          full;
  logic          push_ok;
  logic          ovr_evt;
  logic [7:0]    head_n;

  // Byte assembly FSM; L2H_Sig only matters in SHIFT, En only in IDLE.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      sta       <= IDLE;
      shift_reg <= 8'h00;
      bit_cnt   <= 3'd0;
    end else begin
      case (sta)
        IDLE: begin
          if (En) begin
            sta     <= SHIFT;
            bit_cnt <= 3'd0;
          end
        end
        SHIFT: begin
          if (L2H_Sig) begin
            shift_reg <= {shift_reg[6:0], MISO};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) sta <= DONE;
          end
        end
        DONE:    sta <= IDLE;
        default: sta <= IDLE;
      endcase
    end
  end

  assign Busy_Sig = (sta != IDLE);
  assign Done_Sig = (sta == DONE);
  assign Sta_Dbg  = sta;

  // A pop frees the slot in the same cycle, so a push onto a full FIFO
  // coinciding with a read is accepted.
  always_comb begin
    push     = (sta == DONE);
    pop      = Rd_En && (count != '0);
    full     = (count == CW'(FIFO_DEPTH));
    push_ok  = push && (!full || pop);
    ovr_evt  = push && full && !pop;
    rd_ptr_n = pop ? rd_ptr + PW'(1) : rd_ptr;
    count_n  = count;
    if (push_ok && !pop)      count_n = count + CW'(1);
    else if (!push_ok && pop) count_n = count - CW'(1);
    head_n   = (push_ok && (rd_ptr_n == wr_ptr)) ? shift_reg : mem[rd_ptr_n];
  end

  always_ff @(posedge CLK) begin
    if (RSTn && push_ok) mem[wr_ptr] <= shift_reg;
  end

  // Data is a registered copy of the next head; it holds when the FIFO drains.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      Data        <= 8'h00;
      Overrun_Sig <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr <= rd_ptr_n;
      count  <= count_n;
      if (count_n != '0) Data <= head_n;
      if (ovr_evt)      Overrun_Sig <= 1'b1;
      else if (Clr_Ovr) Overrun_Sig <= 1'b0;
    end
  end

  assign Empty_Sig = (count == '0);
  assign Full_Sig  = full;

endmodule

// File: tb/tb_spi_rx_module.sv
// Bench for spi_rx_module: directed scenarios plus random bytes, checked
// against a byte-queue model of the receiver and FIFO.
module tb_spi_rx_module;

  localparam int DEPTH = 2;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       MISO;
  logic       En;
  logic       L2H_Sig;
  logic       Rd_En;
  logic       Clr_Ovr;
  logic       Busy_Sig;
  logic       Done_Sig;
  logic [7:0] Data;
  logic       Empty_Sig;
  logic       Full_Sig;
  logic       Overrun_Sig;
  logic [1:0] Sta_Dbg;

  spi_rx_module #(.FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RSTn(RSTn), .MISO(MISO), .En(En), .L2H_Sig(L2H_Sig),
    .Rd_En(Rd_En), .Clr_Ovr(Clr_Ovr), .Busy_Sig(Busy_Sig), .Done_Sig(Done_Sig),
    .Data(Data), .Empty_Sig(Empty_Sig), .Full_Sig(Full_Sig),
    .Overrun_Sig(Overrun_Sig), .Sta_Dbg(Sta_Dbg)
  );

  // Clock / reset
  always #5 CLK = ~CLK;

  // Model and scoreboard state
  logic [7:0] exp_q[$];
  logic [7:0] exp_data;
  logic       exp_ovr;
  int         exp_done;
  int         done_seen;
  int         cmp_cnt;
  int         fail_cnt;

  always @(negedge CLK) if (RSTn === 1'b1 && Done_Sig === 1'b1) done_seen++;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_head();
    if (exp_q.size() > 0) exp_data = exp_q[0];
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_empty"}, Empty_Sig, exp_q.size() == 0);
    chk({tag, "_full"}, Full_Sig, exp_q.size() == DEPTH);
    chk({tag, "_ovr"}, Overrun_Sig, exp_ovr);
    chk({tag, "_data"}, Data, exp_data);
    chk({tag, "_busy"}, Busy_Sig, 1'b0);
    chk({tag, "_done"}, Done_Sig, 1'b0);
  endtask

  // Driver: one byte MSB first; options exercise the ignored-event rules.
  task automatic recv_byte(input logic [7:0] b, input bit rd_done, input bit clr_done,
                           input bit en_l2h, input bit en_mid, input int gap);
    bit evt;
    En = 1'b1;
    if (en_l2h) begin
      L2H_Sig = 1'b1;
      MISO    = 1'($urandom_range(0, 1));
    end
    cyc();
    En = 1'b0;
    L2H_Sig = 1'b0;
    cyc();
    chk("busy_start", Busy_Sig, 1'b1);
    for (int i = 7; i >= 0; i--) begin
      MISO    = b[i];
      L2H_Sig = 1'b1;
      if (en_mid && i == 4) En = 1'b1;
      cyc();
      L2H_Sig = 1'b0;
      En      = 1'b0;
      MISO    = 1'($urandom_range(0, 1));
      if (i > 0) repeat (gap) cyc();
    end
    chk("done_pulse", Done_Sig, 1'b1);
    chk("busy_in_done", Busy_Sig, 1'b1);
    Rd_En   = rd_done;
    Clr_Ovr = clr_done;
    cyc();
    Rd_En   = 1'b0;
    Clr_Ovr = 1'b0;
    evt = 1'b0;
    if (rd_done && exp_q.size() > 0) void'(exp_q.pop_front());
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else evt = 1'b1;
    if (evt) exp_ovr = 1'b1;
    else if (clr_done) exp_ovr = 1'b0;
    exp_done++;
    model_head();
    check_outs("byte");
  endtask

  task automatic read_one();
    Rd_En = 1'b1;
    cyc();
    Rd_En = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    model_head();
    check_outs("read");
  endtask

  task automatic clear_ovr();
    Clr_Ovr = 1'b1;
    cyc();
    Clr_Ovr = 1'b0;
    exp_ovr = 1'b0;
    check_outs("clr");
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_ovr  = 1'b0;
    exp_data = 8'h00;
  endtask

  initial begin
    cmp_cnt = 0; fail_cnt = 0; exp_done = 0; done_seen = 0;
    RSTn = 1'b0; MISO = 1'b0; En = 1'b0; L2H_Sig = 1'b0; Rd_En = 1'b0; Clr_Ovr = 1'b0;
    model_reset();

    repeat (3) cyc();
    check_outs("reset_held");
    RSTn = 1'b1;
    cyc();
    check_outs("reset_rel");
    chk("reset_no_done", done_seen, 0);

    recv_byte(8'hA5, 0, 0, 0, 0, 1);
    chk("a5_data", Data, 8'hA5);
    read_one();
    chk("a5_empty", Empty_Sig, 1'b1);

    recv_byte(8'h3C, 0, 0, 0, 0, 1);
    recv_byte(8'h81, 0, 0, 0, 0, 2);
    chk("fill_full", Full_Sig, 1'b1);
    recv_byte(8'hFF, 0, 0, 0, 0, 1);
    chk("fill_ovr", Overrun_Sig, 1'b1);
    chk("fill_head", Data, 8'h3C);
    read_one();
    chk("fill_rd2", Data, 8'h81);
    read_one();
    chk("fill_hold", Data, 8'h81);
    clear_ovr();

    recv_byte(8'h11, 0, 0, 0, 0, 1);
    recv_byte(8'h22, 0, 0, 0, 0, 1);
    recv_byte(8'h33, 1, 0, 0, 0, 1);
    chk("pp_no_ovr", Overrun_Sig, 1'b0);
    chk("pp_head", Data, 8'h22);
    read_one();
    chk("pp_second", Data, 8'h33);
    read_one();

    recv_byte(8'h44, 0, 0, 0, 0, 1);
    recv_byte(8'h55, 0, 0, 0, 0, 1);
    recv_byte(8'h66, 0, 1, 0, 0, 1);
    chk("set_wins", Overrun_Sig, 1'b1);
    clear_ovr();
    read_one();
    read_one();

    for (int i = 0; i < 3; i++) begin
      L2H_Sig = 1'b1; MISO = 1'b1;
      cyc();
      L2H_Sig = 1'b0;
      cyc();
    end
    read_one();
    check_outs("idle_l2h");
    recv_byte(8'h5A, 0, 0, 1, 1, 1);
    chk("ign_data", Data, 8'h5A);
    cyc();
    L2H_Sig = 1'b1; MISO = 1'b1;
    cyc();
    L2H_Sig = 1'b0;
    repeat (2) cyc();
    check_outs("exact8");
    read_one();

    En = 1'b1;
    cyc();
    En = 1'b0;
    for (int i = 7; i >= 4; i--) begin
      MISO = 1'b1; L2H_Sig = 1'b1;
      cyc();
      L2H_Sig = 1'b0;
      cyc();
    end
    RSTn = 1'b0;
    cyc();
    RSTn = 1'b1;
    model_reset();
    cyc();
    check_outs("mid_rst");
    chk("mid_rst_done", done_seen, exp_done);
    recv_byte(8'h0F, 0, 0, 0, 0, 1);
    chk("after_rst", Data, 8'h0F);
    read_one();

    for (int n = 0; n < 24; n++) begin
      recv_byte(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
      repeat ($urandom_range(0, 2)) read_one();
      if ($urandom_range(0, 3) == 0) clear_ovr();
    end
    while (exp_q.size() > 0) read_one();
    read_one();

    chk("done_total", done_seen, exp_done);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
